// File: rtl/spi_flash_reader.sv
// spi_flash_reader: fetches one 32-bit word from a mode-0 SPI flash per request.
// Frame on spi_mosi is {READ_CMD, 24-bit address} MSB first, then DUMMY_CYCLES
// turnaround clocks, then 32 data bits from spi_miso. The word is returned
// little-endian: the first byte received from the flash lands in rd_rdata[7:0].
//
// Request handshake: a read is accepted on the clk edge where
// rd_valid && rd_ready. rd_ready is high only in IDLE. rd_addr is sampled only
// on that edge. A request presented while busy is ignored (no queuing).
// rd_rvalid is a one-cycle pulse. rd_rdata holds its value until the next
// transaction completes.
//
// All outputs are registered. The FSM state is kept in the named enum signal
// state_q so checkers can bind to it directly.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned DUMMY_CYCLES = 1,
  parameter logic [7:0]  READ_CMD     = 8'h03,
  parameter int unsigned CS_HIGH      = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        rd_valid,
  input  logic [23:0] rd_addr,
  output logic        rd_ready,
  output logic [31:0] rd_rdata,
  output logic        rd_rvalid,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    DUMMY = 3'd2,
    DATA  = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Last phase count of a half bit period, and of the chip-select high gap.
  localparam logic [7:0] PH_LAST    = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST   = 8'(CS_HIGH - 1);
  // The bit counter runs across the whole frame: command, dummy, then data.
  localparam logic [6:0] CMD_LAST   = 7'd31;
  localparam logic [6:0] DUMMY_LAST = 7'(31 + DUMMY_CYCLES);
  localparam logic [6:0] DATA_LAST  = 7'(63 + DUMMY_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;     // clk count within a half period, or within GAP
  logic        half_q, half_d;       // 0: low phase, 1: high phase of the bit period
  logic [6:0]  bit_q, bit_d;
  logic [31:0] shift_out_q, shift_out_d;
  logic [31:0] shift_in_q, shift_in_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    half_d      = half_q;
    bit_d       = bit_q;
    shift_out_d = shift_out_q;
    shift_in_d  = shift_in_q;
    cs_n_d      = cs_n_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (rd_valid && ready_q) begin
          state_d     = CMD;
          cs_n_d      = 1'b0;
          sclk_d      = 1'b0;
          half_d      = 1'b0;
          phase_d     = 8'd0;
          bit_d       = 7'd0;
          // The first frame bit goes out with cs_n; the rest is pre-shifted.
          mosi_d      = READ_CMD[7];
          shift_out_d = {READ_CMD[6:0], rd_addr, 1'b0};
          shift_in_d  = 32'd0;
        end
      end

      CMD, DUMMY, DATA: begin
        if (phase_q != PH_LAST) begin
          phase_d = phase_q + 8'd1;
        end else begin
          phase_d = 8'd0;
          if (!half_q) begin
            // End of the low phase: spi_clk rises next, so capture miso now.
            half_d = 1'b1;
            sclk_d = 1'b1;
            if (state_q == DATA) begin
              shift_in_d = {shift_in_q[30:0], spi_miso};
            end
          end else begin
            // End of the bit period.
            half_d = 1'b0;
            sclk_d = 1'b0;
            bit_d  = bit_q + 7'd1;
            case (state_q)
              CMD: begin
                if (bit_q == CMD_LAST) begin
                  mosi_d  = 1'b0;
                  state_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
                end else begin
                  mosi_d      = shift_out_q[31];
                  shift_out_d = {shift_out_q[30:0], 1'b0};
                end
              end
              DUMMY: begin
                if (bit_q == DUMMY_LAST) begin
                  state_d = DATA;
                end
              end
              default: begin
                if (bit_q == DATA_LAST) begin
                  state_d  = GAP;
                  cs_n_d   = 1'b1;
                  rvalid_d = 1'b1;
                  rdata_d  = {shift_in_q[7:0], shift_in_q[15:8],
                              shift_in_q[23:16], shift_in_q[31:24]};
                end
              end
            endcase
          end
        end
      end

      GAP: begin
        // cs_n stays high for CS_HIGH cycles before the next request is taken.
        if (phase_q == GAP_LAST) begin
          state_d = IDLE;
          phase_d = 8'd0;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q     <= IDLE;
      phase_q     <= 8'd0;
      half_q      <= 1'b0;
      bit_q       <= 7'd0;
      shift_out_q <= 32'd0;
      shift_in_q  <= 32'd0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      half_q      <= half_d;
      bit_q       <= bit_d;
      shift_out_q <= shift_out_d;
      shift_in_q  <= shift_in_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      ready_q     <= (state_d == IDLE);
    end
  end

  assign rd_ready  = ready_q;
  assign rd_rdata  = rdata_q;
  assign rd_rvalid = rvalid_q;
  assign spi_cs_n  = cs_n_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three instances (default, CLK_DIV=1/DUMMY=0,
// CLK_DIV=5), each attached to a small behavioural mode-0 SPI flash model
// that shares one word memory.
module tb_spi_flash_reader;

  logic clk;
  logic RESET;

  logic [2:0]        rd_valid;
  logic [2:0][23:0]  rd_addr;
  wire  [2:0]        rd_ready;
  wire  [2:0][31:0]  rdata;
  wire  [2:0]        rvalid;
  wire  [2:0]        cs_n;
  wire  [2:0]        sclk;
  wire  [2:0]        mosi;
  wire  [2:0]        miso;

  logic [31:0] mem [16];
  logic [31:0] exp_q [$];

  int total;
  int bad;

  // Clock and global watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  spi_flash_reader u0 (
    .clk(clk), .RESET(RESET), .rd_valid(rd_valid[0]), .rd_addr(rd_addr[0]),
    .rd_ready(rd_ready[0]), .rd_rdata(rdata[0]), .rd_rvalid(rvalid[0]),
    .spi_cs_n(cs_n[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0])
  );

  spi_flash_reader #(.CLK_DIV(1), .DUMMY_CYCLES(0)) u1 (
    .clk(clk), .RESET(RESET), .rd_valid(rd_valid[1]), .rd_addr(rd_addr[1]),
    .rd_ready(rd_ready[1]), .rd_rdata(rdata[1]), .rd_rvalid(rvalid[1]),
    .spi_cs_n(cs_n[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1])
  );

  spi_flash_reader #(.CLK_DIV(5)) u2 (
    .clk(clk), .RESET(RESET), .rd_valid(rd_valid[2]), .rd_addr(rd_addr[2]),
    .rd_ready(rd_ready[2]), .rd_rdata(rdata[2]), .rd_rvalid(rvalid[2]),
    .spi_cs_n(cs_n[2]), .spi_clk(sclk[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2])
  );

  // Flash models: capture the 32-bit frame on rising spi_clk, then drive the
  // addressed word little-endian (byte 0 first, each byte MSB first) on
  // falling spi_clk after the turnaround clocks.
  for (genvar g = 0; g < 3; g++) begin : g_flash
    localparam int D = (g == 1) ? 0 : 1;
    int          rise_cnt;
    int          k;
    logic [31:0] frame;
    logic        m_out;

    initial begin
      rise_cnt = 0;
      k        = 0;
      frame    = 32'd0;
      m_out    = 1'b0;
    end

    always @(negedge cs_n[g]) begin
      rise_cnt = 0;
      frame    = 32'd0;
      m_out    = 1'b0;
    end

    always @(posedge sclk[g]) begin
      if (!cs_n[g]) begin
        rise_cnt = rise_cnt + 1;
        if (rise_cnt <= 32) frame = {frame[30:0], mosi[g]};
      end
    end

    always @(negedge sclk[g]) begin
      if (!cs_n[g]) begin
        k = rise_cnt - (32 + D);
        if (k >= 0 && k < 32) m_out = mem[frame[5:2]][8 * (k / 8) + 7 - (k % 8)];
      end
    end

    assign miso[g] = m_out;
  end

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: wait for rd_ready, present a request, return in cycle 1 after the
  // accept edge. With hold set, rd_valid stays high afterwards.
  task automatic send(input int i, input logic [23:0] a, input bit hold);
    int w;
    w = 0;
    while (rd_ready[i] !== 1'b1 && w < 1000) begin
      @(posedge clk); #1; w++;
    end
    rd_valid[i] = 1'b1;
    rd_addr[i]  = a;
    @(posedge clk); #1;
    if (!hold) rd_valid[i] = 1'b0;
    check({"cs_n_low_cycle1_", $sformatf("%0d", i)}, {31'd0, cs_n[i]}, 32'd0);
  endtask

  // Wait (bounded) for rd_rvalid starting from cycle 1, then score it.
  task automatic wait_done(input int i, input int exp_lat, input string tag);
    int   cnt;
    bit   rdy_hi;
    logic [31:0] exp;
    cnt    = 1;
    rdy_hi = 1'b0;
    while (rvalid[i] !== 1'b1 && cnt < 2000) begin
      if (rd_ready[i] === 1'b1) rdy_hi = 1'b1;
      @(posedge clk); #1; cnt++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000;
    check({tag, "_latency"}, cnt, exp_lat);
    check({tag, "_ready_low"}, {31'd0, rdy_hi}, 32'd0);
    check({tag, "_rdata"}, rdata[i], exp);
    check({tag, "_cs_sclk_at_rvalid"}, {30'd0, cs_n[i], sclk[i]}, 32'd2);
  endtask

  initial begin
    int g;
    int pulses;
    total    = 0;
    bad      = 0;
    RESET    = 1'b1;
    rd_valid = 3'b000;
    rd_addr  = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'h1234_5678;
    mem[1] = 32'hA5C3_0F96;
    mem[2] = 32'h0BAD_F00D;
    mem[3] = 32'hDEAD_BEEF;
    mem[5] = 32'hC0FF_EE01;
    mem[6] = 32'h8BAD_CAFE;

    // Reset state.
    repeat (5) @(posedge clk);
    #1;
    check("rst_cs_n",   {31'd0, cs_n[0]},     32'd1);
    check("rst_sclk",   {31'd0, sclk[0]},     32'd0);
    check("rst_mosi",   {31'd0, mosi[0]},     32'd0);
    check("rst_ready",  {29'd0, rd_ready},    32'd7);
    check("rst_rvalid", {29'd0, rvalid},      32'd0);
    check("rst_rdata",  rdata[0],             32'd0);
    RESET = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Basic read, defaults.
    send(0, 24'h000000, 1'b0);
    exp_q.push_back(32'h1234_5678);
    wait_done(0, 261, "basic");
    check("basic_frame", g_flash[0].frame, 32'h0300_0000);
    check("basic_rises", g_flash[0].rise_cnt, 32'd65);

    // Address path.
    repeat (4) @(posedge clk);
    #1;
    send(0, 24'h00000C, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_done(0, 261, "addr");
    check("addr_frame", g_flash[0].frame, 32'h0300_000C);

    // Back-to-back with rd_valid held high; the address changes while busy.
    repeat (4) @(posedge clk);
    #1;
    send(0, 24'h000004, 1'b1);
    rd_addr[0] = 24'h000008;
    exp_q.push_back(32'hA5C3_0F96);
    wait_done(0, 261, "b2b_first");
    check("b2b_first_frame", g_flash[0].frame, 32'h0300_0004);
    g = 0;
    while (cs_n[0] === 1'b1 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    rd_valid[0] = 1'b0;
    check("b2b_cs_gap", g, 32'd3);
    check("b2b_rdata_held", rdata[0], 32'hA5C3_0F96);
    exp_q.push_back(32'h0BAD_F00D);
    wait_done(0, 261, "b2b_second");
    check("b2b_second_frame", g_flash[0].frame, 32'h0300_0008);

    // Parameter sweep: CLK_DIV=1 with no turnaround, then CLK_DIV=5.
    send(1, 24'h000014, 1'b0);
    exp_q.push_back(32'hC0FF_EE01);
    wait_done(1, 129, "div1");
    check("div1_frame", g_flash[1].frame, 32'h0300_0014);
    check("div1_rises", g_flash[1].rise_cnt, 32'd64);

    send(2, 24'h000018, 1'b0);
    exp_q.push_back(32'h8BAD_CAFE);
    wait_done(2, 651, "div5");
    check("div5_frame", g_flash[2].frame, 32'h0300_0018);

    // Reset during the data phase.
    repeat (4) @(posedge clk);
    #1;
    send(0, 24'h000000, 1'b0);
    repeat (149) @(posedge clk);
    #1;
    check("mid_cs_low_before_reset", {31'd0, cs_n[0]}, 32'd0);
    RESET = 1'b1;
    @(posedge clk); #1;
    RESET = 1'b0;
    check("mid_cs_n",   {31'd0, cs_n[0]},     32'd1);
    check("mid_sclk",   {31'd0, sclk[0]},     32'd0);
    check("mid_ready",  {31'd0, rd_ready[0]}, 32'd1);
    check("mid_rvalid", {31'd0, rvalid[0]},   32'd0);
    pulses = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (rvalid[0] === 1'b1) pulses++;
    end
    check("mid_no_rvalid", pulses, 32'd0);
    send(0, 24'h00000C, 1'b0);
    exp_q.push_back(32'hDEAD_BEEF);
    wait_done(0, 261, "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI initiator that fetches one 32-bit word from the external SPI flash per request.
- Sends a 32-bit command/address frame (read opcode plus 24-bit byte address) MSB-first on spi_mosi.
- Clocks out DUMMY_CYCLES turnaround clocks, then shifts in 32 data bits from spi_miso.
- Sits between the femtosoc memory-mapped bus and the flash pins; returns the word little-endian (first received byte in bits [7:0]).

Parameters:
- CLK_DIV, 2: clk cycles per spi_clk half-period; legal range 1..255.
- DUMMY_CYCLES, 1: spi_clk rising edges between the last command bit and the first data bit; legal range 0..15.
- READ_CMD, 8'h03: opcode placed in frame bits [31:24].
- CS_HIGH, 2: minimum clk cycles spi_cs_n stays high between transactions; legal range 1..255.

Ports:
- clk  input  1  system clock.
- RESET  input  1  synchronous, active-high reset.
- rd_valid  input  1  read request.
- rd_addr  input  24  flash byte address; sent unmodified.
- rd_ready  output  1  high only in IDLE; a request is accepted on the clk edge where rd_valid && rd_ready.
- rd_rdata  output  32  read data; held stable until the next accept.
- rd_rvalid  output  1  one-cycle pulse: rd_rdata is valid.
- spi_cs_n  output  1  flash chip select, active low.
- spi_clk  output  1  SPI clock, idle low (mode 0).
- spi_mosi  output  1  serial data to flash.
- spi_miso  input  1  serial data from flash.

Behaviour:
- Reset values, all registered: spi_cs_n=1, spi_clk=0, spi_mosi=0, rd_rvalid=0, rd_rdata=0, rd_ready=1, state=IDLE.
- Reset asserted mid-transaction:
  - Next cycle: cs_n=1, spi_clk=0, state=IDLE.
  - No rd_rvalid is issued and the partial word is discarded.
- States and transitions:
  - IDLE -> CMD on accept. Latch shift_out={READ_CMD, rd_addr}. cs_n falls on the cycle after accept (cycle 1).
  - CMD: 32 bits -> DUMMY, or -> DATA if DUMMY_CYCLES=0.
  - DUMMY: DUMMY_CYCLES bit periods -> DATA. mosi=0; miso is ignored.
  - DATA: 32 bits -> GAP.
  - GAP: cs_n=1 for CS_HIGH cycles -> IDLE.
- Bit period = 2*CLK_DIV clk cycles, split into a low phase then a high phase (spi_clk=0 for CLK_DIV cycles, then spi_clk=1 for CLK_DIV cycles).
  - CMD: spi_mosi updates to the next frame bit (MSB first) on the first cycle of the low phase.
  - DATA: spi_miso is sampled on the last clk of the low phase, i.e. the cycle before spi_clk rises, and shifted into shift_in LSB.
- Total spi_cs_n low time = (32 + DUMMY_CYCLES + 32) * 2 * CLK_DIV clk cycles, i.e. exactly 64+DUMMY_CYCLES rising edges.
- spi_clk returns to 0 in the cycle cs_n rises.
- In that same cycle:
  - rd_rvalid=1.
  - rd_rdata = {shift_in[7:0], shift_in[15:8], shift_in[23:16], shift_in[31:24]}.
- Latency, accept to rd_rvalid: 1 + (64+DUMMY_CYCLES)*2*CLK_DIV cycles. Default: 261.
- Next accept is possible at the earliest CS_HIGH cycles after rd_rvalid.
- rd_valid while not in IDLE: ignored, no queuing. rd_addr is sampled only at accept.
- Counters:
  - Bit counter: 7 bits.
  - Phase counter: 8 bits, wraps to 0 at CLK_DIV-1.
  - No counter ever overflows for the legal parameter ranges.

Test Plan:
- Reset state: hold RESET 5 cycles -> cs_n=1, spi_clk=0, mosi=0, rd_ready=1, rd_rvalid=0.
- Basic read against the flash model (defaults, MEM[0]=32'h12345678, rd_addr=0):
  - mosi frame captured by the model = 32'h03000000.
  - rd_rvalid exactly 261 cycles after accept, rd_rdata=32'h12345678.
  - Exactly 65 spi_clk rising edges while cs_n low.
- Address path: MEM[3]=32'hDEADBEEF, rd_addr=24'h00000C -> frame 32'h0300000C, rd_rdata=32'hDEADBEEF.
- Back-to-back requests: rd_valid held high with two addresses.
  - rd_ready low during the transaction.
  - Second cs_n fall no earlier than 3 cycles after the first rd_rvalid (1 cycle after CS_HIGH=2 high cycles).
  - Both words are correct.
- Parameter sweep: CLK_DIV=1, DUMMY_CYCLES=0 on a model with no turnaround -> latency 129 cycles, data correct. CLK_DIV=5 -> latency 651.
- Reset mid-DATA: assert RESET at cycle 150 after accept.
  - Next cycle cs_n=1, spi_clk=0.
  - No rd_rvalid.
  - A new request afterwards returns the correct word.
